// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end: lane map and debounce FSM states.
package btn_pkg;

    localparam int NUM_BTN_C = 3;

    localparam int BTN_CLR   = 0;
    localparam int BTN_START = 1;
    localparam int BTN_STOP  = 2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_PRESS = 2'd1,
        PRESSED    = 2'd2,
        WAIT_REL   = 2'd3
    } db_state_t;

endpackage : btn_pkg

// File: rtl/debounce_lane.sv
// One button lane: two-flop synchroniser followed by a counting debounce FSM
// that emits a clean level plus single-cycle press/release pulses.
module debounce_lane
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    // Only s2 is allowed to steer the FSM; s1 may still be metastable.
    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = WAIT_PRESS;
                    cnt_d   = '0;
                end
            end
            WAIT_PRESS: begin
                if (!s2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s2_q) begin
                    state_d = WAIT_REL;
                    cnt_d   = '0;
                end
            end
            WAIT_REL: begin
                if (s2_q) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;

endmodule : debounce_lane

// File: rtl/btn_conditioner.sv
// Reaction-game button front end: one independent debounce lane per button.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTN   = NUM_BTN_C,
    parameter int DB_CYCLES = 2_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_rel
);

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_lane
            debounce_lane #(
                .DB_CYCLES(DB_CYCLES)
            ) u_lane (
                .clk  (clk),
                .rst  (rst),
                .raw  (btn_raw[gi]),
                .level(btn_level[gi]),
                .press(btn_press[gi]),
                .rel  (btn_rel[gi])
            );
        end
    endgenerate

endmodule : btn_conditioner
